rgbw_pixel_converter: RTL and testbench

Read-side consumer of the 256 x 32 asynchronous pixel FIFO. Runs entirely in the FIFO read clock domain and pops one 32-bit RGB word at a time. Each word is converted to RGBW by extracting the common white component, then presented as a GRBW word to the downstream LED serializer over a valid/ready handshake. Tracks pixel position in the frame and flags the last pixel.

---
 rtl/rgbw_pkg.sv | 22 ++
 rtl/rgbw_min3.sv | 18 +
 rtl/rgbw_pixel_converter.sv | 130 +++++++++++++
 tb/tb_rgbw_pixel_converter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgbw_pkg.sv
// rtl/rgbw_pkg.sv - shared constants and FSM encoding for the RGBW pixel converter
package rgbw_pkg;

  localparam int CHAN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Channel slot k occupies bits [k*CHAN_BITS +: CHAN_BITS] of a word.
  localparam int IN_R_SLOT  = 2;
  localparam int IN_G_SLOT  = 1;
  localparam int IN_B_SLOT  = 0;

  localparam int OUT_G_SLOT = 3;
  localparam int OUT_R_SLOT = 2;
  localparam int OUT_B_SLOT = 1;
  localparam int OUT_W_SLOT = 0;

endpackage

// File: rtl/rgbw_min3.sv
// rtl/rgbw_min3.sv - combinational unsigned minimum of three channel values
module rgbw_min3 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  logic [W-1:0] ab;

  always_comb begin
    ab = (a < b) ? a : b;
    y  = (ab < c) ? ab : c;
  end

endmodule

// File: rtl/rgbw_pixel_converter.sv
// rtl/rgbw_pixel_converter.sv - FIFO-fed RGB to GRBW converter; RGBW_ADDITIVE_WHITE_EN keeps RGB unsubtracted
module rgbw_pixel_converter
  import rgbw_pkg::*;
#(
  parameter int DATA_SIZE        = 32,
  parameter int CHAN_BITS        = CHAN_W,
  parameter int PIXELS_PER_FRAME = 16
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic [DATA_SIZE-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  localparam int CNT_W = (PIXELS_PER_FRAME > 1) ? $clog2(PIXELS_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS_PER_FRAME - 1);

  state_t state, state_next;

  logic [CHAN_BITS-1:0] r_q, g_q, b_q;
  logic [CHAN_BITS-1:0] r_o, g_o, b_o, w_o;
  logic [CHAN_BITS-1:0] r_new, g_new, b_new, w_min;
  logic [CNT_W-1:0]     pixel_cnt;
  logic                 last_q;

  // Bits above the RGB fields carry nothing for this block.
  logic unused_fifo_bits;
  assign unused_fifo_bits = ^fifo_data;

  rgbw_min3 #(.W(CHAN_BITS)) u_min3 (
    .a (r_q),
    .b (g_q),
    .c (b_q),
    .y (w_min)
  );

`ifdef RGBW_ADDITIVE_WHITE_EN
  assign r_new = r_q;
  assign g_new = g_q;
  assign b_new = b_q;
`else
  assign r_new = r_q - w_min;
  assign g_new = g_q - w_min;
  assign b_new = b_q - w_min;
`endif

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (!fifo_empty) state_next = ST_CALC;
      ST_CALC: state_next = ST_OUT;
      ST_OUT:  if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Pop is combinational so the word is consumed in the cycle it is latched;
  // the reset term keeps the strobe quiet while the FSM is held.
  always_comb begin
    fifo_rd_en = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy       = 1'b0;
        fifo_rd_en = !fifo_empty && !r_rst;
      end
      ST_OUT:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      r_o       <= '0;
      g_o       <= '0;
      b_o       <= '0;
      w_o       <= '0;
      last_q    <= 1'b0;
      pixel_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            r_q <= fifo_data[IN_R_SLOT*CHAN_BITS +: CHAN_BITS];
            g_q <= fifo_data[IN_G_SLOT*CHAN_BITS +: CHAN_BITS];
            b_q <= fifo_data[IN_B_SLOT*CHAN_BITS +: CHAN_BITS];
          end
        end
        ST_CALC: begin
          r_o    <= r_new;
          g_o    <= g_new;
          b_o    <= b_new;
          w_o    <= w_min;
          last_q <= (pixel_cnt == LAST_IDX);
        end
        ST_OUT: begin
          if (out_ready)
            pixel_cnt <= (pixel_cnt == LAST_IDX) ? '0 : pixel_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    out_data[OUT_G_SLOT*CHAN_BITS +: CHAN_BITS] = g_o;
    out_data[OUT_R_SLOT*CHAN_BITS +: CHAN_BITS] = r_o;
    out_data[OUT_B_SLOT*CHAN_BITS +: CHAN_BITS] = b_o;
    out_data[OUT_W_SLOT*CHAN_BITS +: CHAN_BITS] = w_o;
  end

  assign out_last = last_q && (state == ST_OUT);

endmodule

// File: tb/tb_rgbw_pixel_converter.sv
// tb/tb_rgbw_pixel_converter.sv - scoreboard bench for rgbw_pixel_converter
module tb_rgbw_pixel_converter;

  localparam int PPF = 16;

  logic        r_clk = 1'b0;
  logic        r_rst = 1'b1;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] src_mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [32:0] sb_q [$];
  int          tb_cnt = 0;
  int          hs_count = 0;
  logic        last_log [0:1023];
  logic [32:0] mon_exp;
  logic        pop_s, emp_s;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = src_mem[rd_ptr[7:0]];

  rgbw_pixel_converter dut (
    .r_clk      (r_clk),
    .r_rst      (r_rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 r_clk = ~r_clk;

  // FIFO model: a pop strobe seen at the edge consumes the head word.
  always @(posedge r_clk) begin
    pop_s = fifo_rd_en;
    emp_s = fifo_empty;
    #1;
    if (pop_s) begin
      n_cmp++;
      if (emp_s) begin
        n_err++;
        $display("FAIL pop_on_empty: fifo_rd_en=1 while fifo_empty=1 required no pop");
      end else begin
        rd_ptr++;
      end
    end
  end

  // Output monitor: a handshake sampled here completes at the next rising edge.
  always @(negedge r_clk) begin
    if (!r_rst && out_valid && out_ready) begin
      last_log[hs_count[9:0]] = out_last;
      hs_count++;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got data=%08h last=%0b, required no output", out_data, out_last);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({out_last, out_data} !== mon_exp) begin
          n_err++;
          $display("FAIL sb_data: got last=%0b data=%08h, required last=%0b data=%08h",
                   out_last, out_data, mon_exp[32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] word);
    logic [7:0] r, g, b, w, ro, go, bo;
    r = word[23:16];
    g = word[15:8];
    b = word[7:0];
    w = (r < g) ? r : g;
    w = (w < b) ? w : b;
`ifdef RGBW_ADDITIVE_WHITE_EN
    ro = r;
    go = g;
    bo = b;
`else
    ro = r - w;
    go = g - w;
    bo = b - w;
`endif
    src_mem[wr_ptr[7:0]] = word;
    wr_ptr++;
    sb_q.push_back({(tb_cnt == PPF - 1), go, ro, bo, w});
    tb_cnt = (tb_cnt + 1) % PPF;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (!out_valid) begin
      n_err++;
      $display("FAIL %s_timeout: out_valid=0 after %0d cycles, required 1", tag, n);
    end
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < limit) begin
      tick();
      n++;
    end
    n_cmp++;
    if (sb_q.size() != 0 || busy) begin
      n_err++;
      $display("FAIL %s_drain: %0d pixels outstanding busy=%0b, required 0/0", tag, sb_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp += 5;
    if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en: got %0b required 0", fifo_rd_en); end
    if (out_valid  !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b required 0", out_valid); end
    if (out_last   !== 1'b0) begin n_err++; $display("FAIL rst_last: got %0b required 0", out_last); end
    if (out_data   !== 32'h0) begin n_err++; $display("FAIL rst_data: got %08h required 0", out_data); end
    if (busy       !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b required 0", busy); end
    @(negedge r_clk);
    r_rst = 1'b0;
  endtask

  task automatic test_empty();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL empty_idle: cycle %0d rd_en=%0b valid=%0b busy=%0b, required 0/0/0",
                 i, fifo_rd_en, out_valid, busy);
      end
    end
  endtask

  task automatic test_frame();
    int base;
    int n;
    logic want;
    base = hs_count;
    tick();
    for (int k = 0; k < 2 * PPF; k++) push($urandom);
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 600) begin
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    out_ready = 1'b1;
    wait_drain("frame", 20);
    n_cmp++;
    if (hs_count - base !== 2 * PPF) begin
      n_err++;
      $display("FAIL frame_count: got %0d handshakes required %0d", hs_count - base, 2 * PPF);
    end
    for (int k = 0; k < 2 * PPF; k++) begin
      want = ((k % PPF) == PPF - 1);
      n_cmp++;
      if (last_log[(base + k) % 1024] !== want) begin
        n_err++;
        $display("FAIL frame_last: handshake %0d got last=%0b required %0b",
                 k, last_log[(base + k) % 1024], want);
      end
    end
  endtask

  task automatic test_single();
    int base;
    logic [31:0] want;
`ifdef RGBW_ADDITIVE_WHITE_EN
    want = 32'h64_C8_32_32;
`else
    want = 32'h32_96_00_32;
`endif
    tick();
    out_ready = 1'b1;
    base = hs_count;
    push(32'h00_C8_64_32);
    #1;
    n_cmp++;
    if (fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL single_pop: got rd_en=%0b required 1", fifo_rd_en); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || fifo_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL single_calc: valid=%0b busy=%0b rd_en=%0b required 0/1/0", out_valid, busy, fifo_rd_en);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== want) begin
      n_err++;
      $display("FAIL single_out: valid=%0b data=%08h required 1 %08h", out_valid, out_data, want);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || hs_count !== base + 1) begin
      n_err++;
      $display("FAIL single_done: valid=%0b busy=%0b handshakes=%0d required 0/0/1",
               out_valid, busy, hs_count - base);
    end
  endtask

  task automatic test_backpressure();
    int base;
    logic [31:0] held;
    tick();
    out_ready = 1'b0;
    push(32'h00_C8_64_32);
    wait_valid("bp");
    held = out_data;
    push(32'h00_10_20_30);
    base = hs_count;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== held || fifo_rd_en !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold: cycle %0d valid=%0b data=%08h rd_en=%0b required 1 %08h 0",
                 i, out_valid, out_data, fifo_rd_en, held);
      end
    end
    out_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (hs_count !== base + 1) begin
      n_err++;
      $display("FAIL bp_release: got %0d handshakes required 1", hs_count - base);
    end
    wait_drain("bp", 20);
  endtask

  task automatic test_gray_black();
    logic [31:0] words [2];
    logic [31:0] wants [2];
    words[0] = 32'h00_80_80_80;
    words[1] = 32'h0;
`ifdef RGBW_ADDITIVE_WHITE_EN
    wants[0] = 32'h80_80_80_80;
`else
    wants[0] = 32'h00_00_00_80;
`endif
    wants[1] = 32'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      out_ready = 1'b0;
      push(words[i]);
      wait_valid("gray");
      n_cmp++;
      if (out_data !== wants[i]) begin
        n_err++;
        $display("FAIL gray_black: input %08h got %08h required %08h", words[i], out_data, wants[i]);
      end
      out_ready = 1'b1;
      tick();
    end
    wait_drain("gray", 20);
  endtask

  task automatic test_reset_mid();
    int base;
    logic want;
    tick();
    out_ready = 1'b0;
    push(32'h00_11_22_33);
    wait_valid("rstmid");
    #3;
    r_rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_async: valid=%0b busy=%0b data=%08h last=%0b required all 0",
               out_valid, busy, out_data, out_last);
    end
    sb_q.delete();
    tb_cnt = 0;
    @(negedge r_clk);
    r_rst = 1'b0;
    tick();
    out_ready = 1'b1;
    base = hs_count;
    for (int k = 0; k < PPF + 1; k++) push($urandom);
    wait_drain("rstmid", 200);
    n_cmp++;
    if (hs_count - base !== PPF + 1) begin
      n_err++;
      $display("FAIL rstmid_count: got %0d handshakes required %0d", hs_count - base, PPF + 1);
    end
    for (int k = 0; k < PPF + 1; k++) begin
      want = (k == PPF - 1);
      n_cmp++;
      if (last_log[(base + k) % 1024] !== want) begin
        n_err++;
        $display("FAIL rstmid_last: pixel %0d got last=%0b required %0b",
                 k, last_log[(base + k) % 1024], want);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) src_mem[i] = 32'h0;
    test_reset();
    test_empty();
    test_frame();
    test_single();
    test_backpressure();
    test_gray_black();
    test_reset_mid();
    tick();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d pixels never produced, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
